instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is synchronous and active-low.
REQ-002 Parameter: RESET_PC, default 64'h0, address of the first fetch after reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-low reset; asserted when 0, sampled on clk rise.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  64  fetch byte address (equal to current PC).
REQ-007 imem_ready  input  1  memory accepts the request this cycle.
REQ-008 imem_rvalid  input  1  fetch data valid this cycle.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 instr  output  32  registered instruction to decode; decode takes opCode as instr[31:21].
REQ-011 instr_pc  output  64  address of instr.
REQ-012 instr_valid  output  1  instr is valid for decode/control.
REQ-013 decode_ready  input  1  downstream consumes instr this cycle.
REQ-014 BrTaken  input  1  branch-taken from control, valid while instr_valid=1.
REQ-015 UncondBr  input  1  selects the branch offset field, valid while instr_valid=1.
REQ-016 fetch_count  output  32  instructions retired by the handshake, wraps modulo 2^32.

Function
REQ-017 FSM states SHALL be S_IDLE, S_REQ, S_WAIT and S_HOLD, and exactly one request SHALL be outstanding at a time.
REQ-018 S_IDLE: all outputs deasserted; move unconditionally to S_REQ on the next cycle.
REQ-019 S_REQ: imem_req=1 and imem_addr=PC, both stable until imem_ready=1; on imem_ready=1 move to S_WAIT.
REQ-020 S_WAIT: imem_req=0; on imem_rvalid=1 capture imem_rdata into instr and PC into instr_pc, then move to S_HOLD; otherwise wait indefinitely.
REQ-021 imem_rvalid SHALL be ignored in every state other than S_WAIT.
REQ-022 S_HOLD: instr_valid=1 and instr/instr_pc stable; on decode_ready=1 update PC, increment fetch_count and move to S_REQ.
REQ-023 Next PC when BrTaken=0: instr_pc+4.
REQ-024 Next PC when BrTaken=1 and UncondBr=1: instr_pc + (sign-extend instr[25:0] << 2).
REQ-025 Next PC when BrTaken=1 and UncondBr=0: instr_pc + (sign-extend instr[23:5] << 2).
REQ-026 All address arithmetic SHALL be 64-bit and wrap modulo 2^64, with no overflow flag.
REQ-027 BrTaken and UncondBr SHALL be sampled only in the S_HOLD cycle where decode_ready=1.
REQ-028 Minimum throughput: imem_ready and imem_rvalid each in their first eligible cycle, with decode_ready=1, gives one instruction every 3 cycles.

Reset
REQ-029 While reset=0 on a clk rise, the block SHALL set: state=S_IDLE, PC=RESET_PC, instr=0, instr_pc=0, instr_valid=0, imem_req=0, imem_addr=RESET_PC, fetch_count=0.
REQ-030 Reset in any state, including mid-S_WAIT, SHALL abandon the outstanding fetch; any later stale imem_rvalid SHALL be ignored under REQ-021.

Structure
REQ-031 cpu_pkg SHALL hold the fetch_state_t enum and the constants ADDR_W=64, INSTR_W=32 and PC_INC=4.
REQ-032 A sub-module br_target SHALL be combinational, taking instr, instr_pc and UncondBr and producing the 64-bit branch target.

Verification
REQ-033 Sequential fetch: RESET_PC=0, zero-wait memory, BrTaken=0 -> imem_addr takes 0x0, 0x4, 0x8, fetch_count=3 after the third handshake.
REQ-034 B at instr_pc=0x10, instr[31:26]=000101, imm26=3, BrTaken=1, UncondBr=1 -> next imem_addr=0x1C.
REQ-035 CBZ at instr_pc=0x20, imm19=0x7FFFE (-2), BrTaken=1, UncondBr=0 -> next imem_addr=0x18; the same with BrTaken=0 -> 0x24.
REQ-036 Backpressure: imem_ready low for 4 cycles, then decode_ready low for 5 cycles -> imem_addr stable during the first stall; instr, instr_pc and instr_valid stable during the second; no count change.
REQ-037 Reset mid-S_WAIT, then imem_rvalid=1 with 0xDEADBEEF one cycle after reset releases -> instr_valid stays 0 and the first request is at RESET_PC.
REQ-038 Wrap: instr_pc=0xFFFF_FFFF_FFFF_FFFC, BrTaken=0 -> next imem_addr=0x0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths, constants and the fetch FSM state type for the instruction fetch unit.
package cpu_pkg;
  localparam int ADDR_W = 64;
  localparam int INSTR_W = 32;
  localparam logic [ADDR_W-1:0] PC_INC = 64'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_t;
endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory and decode handshake bundle for instr_fetch.
interface instr_fetch_if;
  import cpu_pkg::*;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ready;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               decode_ready;
  logic               BrTaken;
  logic               UncondBr;

  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid,
    input  imem_ready, imem_rvalid, imem_rdata, decode_ready, BrTaken, UncondBr
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid,
    output imem_ready, imem_rvalid, imem_rdata, decode_ready, BrTaken, UncondBr
  );
endinterface

// File: rtl/br_target.sv
// Combinational branch target: instr_pc plus the sign-extended, word-scaled offset field.
module br_target
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  input  logic [ADDR_W-1:0]  instr_pc,
  input  logic               UncondBr,
  output logic [ADDR_W-1:0]  target
);
  logic [ADDR_W-1:0] offset;
  logic              unused_opcode;

  // Opcode bits only matter to decode; the offset fields live below them.
  assign unused_opcode = ^instr[31:26];

  always_comb begin
    if (UncondBr) begin
      offset = {{(ADDR_W-28){instr[25]}}, instr[25:0], 2'b00};
    end else begin
      offset = {{(ADDR_W-21){instr[23]}}, instr[23:5], 2'b00};
    end
  end

  assign target = instr_pc + offset;
endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch: request, wait for data, hold for decode, then advance PC.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus,
  output logic [31:0]   fetch_count
);
  fetch_state_t       state_reg, state_next;
  logic [ADDR_W-1:0]  pc_reg;
  logic [INSTR_W-1:0] instr_reg;
  logic [ADDR_W-1:0]  instr_pc_reg;
  logic [31:0]        count_reg;
  logic               capture;
  logic               retire;
  logic [ADDR_W-1:0]  branch_pc;
  logic [ADDR_W-1:0]  next_pc;

  br_target u_br_target (
    .instr    (instr_reg),
    .instr_pc (instr_pc_reg),
    .UncondBr (bus.UncondBr),
    .target   (branch_pc)
  );

  assign next_pc = bus.BrTaken ? branch_pc : (instr_pc_reg + PC_INC);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    retire     = 1'b0;
    case (state_reg)
      S_IDLE: state_next = S_REQ;
      S_REQ: begin
        if (bus.imem_ready) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          capture    = 1'b1;
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.decode_ready) begin
          retire     = 1'b1;
          state_next = S_REQ;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // rvalid only reaches capture from S_WAIT, so stale data after a reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_reg       <= RESET_PC;
      instr_reg    <= '0;
      instr_pc_reg <= '0;
      count_reg    <= '0;
    end else begin
      if (capture) begin
        instr_reg    <= bus.imem_rdata;
        instr_pc_reg <= pc_reg;
      end
      if (retire) begin
        pc_reg    <= next_pc;
        count_reg <= count_reg + 32'd1;
      end
    end
  end

  assign bus.imem_req    = (state_reg == S_REQ);
  assign bus.imem_addr   = pc_reg;
  assign bus.instr_valid = (state_reg == S_HOLD);
  assign bus.instr       = instr_reg;
  assign bus.instr_pc    = instr_pc_reg;
  assign fetch_count     = count_reg;
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, random transactions, reset corners.
module tb_instr_fetch;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] fetch_count;

  instr_fetch_if bus();

  instr_fetch #(.RESET_PC(64'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] word;
    logic [3:0]  rdly;
    logic [3:0]  vdly;
    logic [3:0]  ddly;
    logic        br;
    logic        unc;
    logic [63:0] addr;
  } vec_t;

  vec_t        tbl [12];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          txn_no = 0;
  logic [63:0] m_pc = 64'h0;
  int unsigned m_cnt = 0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference next-PC from the architectural rule: signed word offset times four.
  function automatic logic [63:0] model_next(logic [63:0] pc, logic [31:0] w, bit br, bit unc);
    longint off;
    if (!br) return pc + 64'd4;
    if (unc) off = longint'($signed(w[25:0]));
    else     off = longint'($signed(w[23:5]));
    return pc + 64'(off * 4);
  endfunction

  task automatic txn(input logic [31:0] word, input int rdly, input int vdly, input int ddly,
                     input bit br, input bit unc, input logic [63:0] exp_addr, output int req_cyc);
    int n = 0;
    while (!bus.imem_req && n < 20) begin
      step();
      n++;
    end
    chk("req_seen", 64'(bus.imem_req), 64'd1);
    chk("req_addr", bus.imem_addr, exp_addr);
    req_cyc = cyc;
    for (int i = 0; i < rdly; i++) begin
      bus.imem_ready  = 1'b0;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = $urandom;
      step();
      chk("req_hold", 64'(bus.imem_req), 64'd1);
      chk("addr_hold", bus.imem_addr, exp_addr);
    end
    bus.imem_ready  = 1'b1;
    bus.imem_rvalid = 1'b0;
    step();
    bus.imem_ready = 1'b0;
    chk("req_drop", 64'(bus.imem_req), 64'd0);
    for (int i = 0; i < vdly; i++) begin
      step();
      chk("no_valid_in_wait", 64'(bus.instr_valid), 64'd0);
    end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = word;
    step();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = $urandom;
    chk("instr_valid", 64'(bus.instr_valid), 64'd1);
    chk("instr", 64'(bus.instr), 64'(word));
    chk("instr_pc", bus.instr_pc, exp_addr);
    for (int i = 0; i < ddly; i++) begin
      bus.decode_ready = 1'b0;
      bus.BrTaken      = 1'b1;
      bus.UncondBr     = 1'($urandom);
      bus.imem_rvalid  = 1'b1;
      step();
      chk("hold_valid", 64'(bus.instr_valid), 64'd1);
      chk("hold_instr", 64'(bus.instr), 64'(word));
      chk("hold_pc", bus.instr_pc, exp_addr);
      chk("hold_count", 64'(fetch_count), 64'(m_cnt));
    end
    bus.imem_rvalid  = 1'b0;
    bus.decode_ready = 1'b1;
    bus.BrTaken      = br;
    bus.UncondBr     = unc;
    step();
    bus.decode_ready = 1'b0;
    bus.BrTaken      = 1'b0;
    bus.UncondBr     = 1'b0;
    m_cnt++;
    m_pc = model_next(exp_addr, word, br, unc);
    chk("count", 64'(fetch_count), 64'(m_cnt));
    chk("valid_drop", 64'(bus.instr_valid), 64'd0);
    chk("next_addr", bus.imem_addr, m_pc);
    $display("txn %0d addr=%h instr=%h br=%0d unc=%0d next=%h count=%0d",
             txn_no, exp_addr, word, br, unc, bus.imem_addr, fetch_count);
    txn_no++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int c0, c1, c2, c3;
    tbl[0]  = '{word: 32'h0000_0000, rdly: 0, vdly: 0, ddly: 0, br: 0, unc: 0, addr: 64'h0};
    tbl[1]  = '{word: 32'h1234_5678, rdly: 0, vdly: 0, ddly: 0, br: 0, unc: 0, addr: 64'h4};
    tbl[2]  = '{word: 32'h8765_4321, rdly: 0, vdly: 0, ddly: 0, br: 0, unc: 1, addr: 64'h8};
    tbl[3]  = '{word: 32'h1400_0001, rdly: 1, vdly: 1, ddly: 1, br: 1, unc: 1, addr: 64'hC};
    tbl[4]  = '{word: 32'h1400_0003, rdly: 0, vdly: 0, ddly: 0, br: 1, unc: 1, addr: 64'h10};
    tbl[5]  = '{word: 32'h1400_0001, rdly: 0, vdly: 2, ddly: 0, br: 1, unc: 1, addr: 64'h1C};
    tbl[6]  = '{word: 32'hB4FF_FFC0, rdly: 0, vdly: 0, ddly: 0, br: 1, unc: 0, addr: 64'h20};
    tbl[7]  = '{word: 32'h1400_0002, rdly: 0, vdly: 0, ddly: 0, br: 1, unc: 1, addr: 64'h18};
    tbl[8]  = '{word: 32'hB4FF_FFC0, rdly: 4, vdly: 0, ddly: 5, br: 0, unc: 0, addr: 64'h20};
    tbl[9]  = '{word: 32'h17FF_FFF6, rdly: 0, vdly: 0, ddly: 0, br: 1, unc: 1, addr: 64'h24};
    tbl[10] = '{word: 32'h1400_0005, rdly: 0, vdly: 0, ddly: 0, br: 0, unc: 1, addr: 64'hFFFF_FFFF_FFFF_FFFC};
    tbl[11] = '{word: 32'hB400_00A0, rdly: 2, vdly: 3, ddly: 1, br: 1, unc: 0, addr: 64'h0};

    bus.imem_ready   = 1'b0;
    bus.imem_rvalid  = 1'b0;
    bus.imem_rdata   = '0;
    bus.decode_ready = 1'b0;
    bus.BrTaken      = 1'b0;
    bus.UncondBr     = 1'b0;
    reset = 1'b0;
    step();
    step();
    chk("rst_req", 64'(bus.imem_req), 64'd0);
    chk("rst_valid", 64'(bus.instr_valid), 64'd0);
    chk("rst_instr", 64'(bus.instr), 64'd0);
    chk("rst_instr_pc", bus.instr_pc, 64'd0);
    chk("rst_count", 64'(fetch_count), 64'd0);
    chk("rst_addr", bus.imem_addr, 64'h0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      txn(tbl[i].word, int'(tbl[i].rdly), int'(tbl[i].vdly), int'(tbl[i].ddly),
          tbl[i].br, tbl[i].unc, tbl[i].addr, c0);
    end

    for (int i = 0; i < 40; i++) begin
      txn($urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          1'($urandom), 1'($urandom), m_pc, c0);
    end

    txn($urandom, 0, 0, 0, 1'b0, 1'b0, m_pc, c1);
    txn($urandom, 0, 0, 0, 1'b0, 1'b0, m_pc, c2);
    txn($urandom, 0, 0, 0, 1'b0, 1'b0, m_pc, c3);
    chk("throughput_a", 64'(c2 - c1), 64'd3);
    chk("throughput_b", 64'(c3 - c2), 64'd3);

    // Reset while a fetch is outstanding, then a stale response arrives.
    bus.imem_ready = 1'b1;
    step();
    bus.imem_ready = 1'b0;
    chk("midwait_req", 64'(bus.imem_req), 64'd0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("midwait_rst_addr", bus.imem_addr, 64'h0);
    chk("midwait_rst_count", 64'(fetch_count), 64'd0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stale_valid", 64'(bus.instr_valid), 64'd0);
      chk("stale_instr", 64'(bus.instr), 64'd0);
    end
    bus.imem_rvalid = 1'b0;
    chk("post_rst_req", 64'(bus.imem_req), 64'd1);
    chk("post_rst_addr", bus.imem_addr, 64'h0);
    m_pc  = 64'h0;
    m_cnt = 0;
    txn(32'h1400_0007, 1, 0, 0, 1'b1, 1'b1, m_pc, c0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
